// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the round-robin select arbiter.
// Used by rr_priority_pick and rr_sel_arbiter (optional burst mode: ARB_BURST_EN).
package rr_arb_pkg;

    localparam int NUM_CH = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // Same encoding as the downstream 2-to-4 decoder: sel=k drives bit k.
    function automatic logic [NUM_CH-1:0] sel2onehot(input logic [1:0] sel);
        sel2onehot = 4'b0001 << sel;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational rotating-priority picker: first requester found searching
// upward from last+1 with wrap; the channel equal to last is checked last.
module rr_priority_pick
    import rr_arb_pkg::*;
(
    input  logic [NUM_CH-1:0] req,
    input  logic [1:0]        last,
    output logic [1:0]        pick,
    output logic              any
);

    always_comb begin
        // NOTE: every output of a combinational block gets a default before any
        // conditional assignment; a path that leaves it unassigned infers a latch.
        pick = '0;
        any  = |req;
        // Walk from lowest priority (offset 4 == last) to highest (offset 1),
        // so the final hit is the winner.
        for (int off = NUM_CH; off >= 1; off--) begin
            if (req[last + 2'(off)]) begin
                pick = last + 2'(off);
            end
        end
    end

endmodule

// File: rtl/rr_sel_arbiter.sv
// Round-robin arbiter driving the 2-bit select of a 4:1 channel mux with a
// valid/ready handshake and per-producer ack. Optional burst mode: ARB_BURST_EN.
module rr_sel_arbiter
    import rr_arb_pkg::*;
#(
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] req,
    output logic [1:0]        sel,
    output logic [NUM_CH-1:0] gnt,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [NUM_CH-1:0] ack
);

`ifdef ARB_BURST_EN
    localparam logic BURST_EN = 1'b1;
`else
    localparam logic BURST_EN = 1'b0;
`endif

    arb_state_t  state_q, state_d;
    logic [1:0]  sel_q, sel_d;
    logic [1:0]  last_q, last_d;
    logic [3:0]  cnt_q, cnt_d;

    logic [1:0]  pick;
    logic        any_req;
    logic        handshake;
    logic        burst_more;

    rr_priority_pick u_pick (
        .req  (req),
        .last (last_q),
        .pick (pick),
        .any  (any_req)
    );

    // A reset cycle aborts the transfer, so it never counts as a handshake.
    always_comb begin
        out_valid  = (state_q == GRANT);
        sel        = sel_q;
        gnt        = out_valid ? sel2onehot(sel_q) : '0;
        handshake  = out_valid && out_ready && !rst;
        ack        = handshake ? gnt : '0;
        burst_more = BURST_EN && req[sel_q] && (int'(cnt_q) < MAX_BURST - 1);
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    sel_d   = pick;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (handshake) begin
                    if (burst_more) begin
                        cnt_d = cnt_q + 4'd1;
                    end else begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        last_d  = sel_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // last resets to 3 so channel 0 wins the first pick.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples its _d value from before the edge, independent of block order.
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= '0;
            last_q  <= 2'd3;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_rr_sel_arbiter.sv
// Self-checking bench for rr_sel_arbiter: directed table, hand sequences and
// random stimulus against a behavioural round-robin model.
module tb_rr_sel_arbiter;

    localparam int MAX_BURST = 4;
`ifdef ARB_BURST_EN
    localparam bit TB_BURST = 1'b1;
`else
    localparam bit TB_BURST = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = '0;
    logic       out_ready = 1'b0;
    logic [1:0] sel;
    logic [3:0] gnt;
    logic       out_valid;
    logic [3:0] ack;

    int n_checks = 0;
    int n_fail   = 0;

    rr_sel_arbiter #(.MAX_BURST(MAX_BURST)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .sel       (sel),
        .gnt       (gnt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ack       (ack)
    );

    always #5 clk = ~clk;

    // Behavioural model: busy flag, granted channel, last served, beat count.
    bit m_known = 1'b0;
    bit m_busy  = 1'b0;
    int m_sel   = 0;
    int m_last  = 3;
    int m_cnt   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [10:0] model_out(input logic r, input logic rd);
        logic [3:0] g;
        logic [3:0] a;
        g = m_busy ? 4'(1 << m_sel) : 4'd0;
        a = (m_busy && rd && !r) ? g : 4'd0;
        return {2'(m_sel), m_busy, g, a};
    endfunction

    task automatic model_step(input logic r, input logic [3:0] rq, input logic rd);
        if (r) begin
            m_busy = 1'b0; m_sel = 0; m_last = 3; m_cnt = 0; m_known = 1'b1;
        end else if (!m_busy) begin
            for (int k = 1; k <= 4; k++) begin
                int ch;
                ch = (m_last + k) % 4;
                if (rq[ch]) begin
                    m_sel = ch; m_busy = 1'b1;
                    break;
                end
            end
        end else if (rd) begin
            if (TB_BURST && rq[m_sel] && m_cnt < MAX_BURST - 1) begin
                m_cnt++;
            end else begin
                m_busy = 1'b0; m_cnt = 0; m_last = m_sel;
            end
        end
    endtask

    // One clock: drive on the falling edge, sample 1 ns later, advance model.
    task automatic cycle(input logic r, input logic [3:0] rq, input logic rd);
        @(negedge clk);
        rst = r; req = rq; out_ready = rd;
        #1;
        if (m_known) check("model", {sel, out_valid, gnt, ack}, model_out(r, rd));
        model_step(r, rq, rd);
    endtask

    task automatic do_reset();
        cycle(1'b1, 4'b0000, 1'b0);
        cycle(1'b1, 4'b0000, 1'b0);
    endtask

    task automatic flush();
        for (int i = 0; i < 4; i++) cycle(1'b0, 4'b0000, 1'b1);
    endtask

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic       rdy;
        logic [1:0] sel;
        logic       vld;
        logic [3:0] gnt;
        logic [3:0] ack;
    } vec_t;

    vec_t tbl[18];

    initial begin
        int starts[$];
        int ack_cnt;
        int last_ack_c;
        logic prev_v;

        // Starting from reset (last=3); no row hands over while req[sel] is
        // high, so the rows hold with or without burst mode.
        tbl[0]  = '{1'b0, 4'b0000, 1'b1, 2'd0, 1'b0, 4'b0000, 4'b0000};
        tbl[1]  = '{1'b0, 4'b1111, 1'b0, 2'd0, 1'b0, 4'b0000, 4'b0000};
        tbl[2]  = '{1'b0, 4'b1111, 1'b0, 2'd0, 1'b1, 4'b0001, 4'b0000};
        tbl[3]  = '{1'b0, 4'b1110, 1'b1, 2'd0, 1'b1, 4'b0001, 4'b0001};
        tbl[4]  = '{1'b0, 4'b1110, 1'b1, 2'd0, 1'b0, 4'b0000, 4'b0000};
        tbl[5]  = '{1'b0, 4'b1100, 1'b1, 2'd1, 1'b1, 4'b0010, 4'b0010};
        tbl[6]  = '{1'b0, 4'b1100, 1'b0, 2'd1, 1'b0, 4'b0000, 4'b0000};
        tbl[7]  = '{1'b0, 4'b1000, 1'b1, 2'd2, 1'b1, 4'b0100, 4'b0100};
        tbl[8]  = '{1'b0, 4'b1000, 1'b0, 2'd2, 1'b0, 4'b0000, 4'b0000};
        tbl[9]  = '{1'b0, 4'b0000, 1'b1, 2'd3, 1'b1, 4'b1000, 4'b1000};
        tbl[10] = '{1'b0, 4'b0011, 1'b0, 2'd3, 1'b0, 4'b0000, 4'b0000};
        tbl[11] = '{1'b0, 4'b0010, 1'b1, 2'd0, 1'b1, 4'b0001, 4'b0001};
        tbl[12] = '{1'b0, 4'b0010, 1'b0, 2'd0, 1'b0, 4'b0000, 4'b0000};
        tbl[13] = '{1'b0, 4'b0000, 1'b1, 2'd1, 1'b1, 4'b0010, 4'b0010};
        tbl[14] = '{1'b0, 4'b0011, 1'b0, 2'd1, 1'b0, 4'b0000, 4'b0000};
        tbl[15] = '{1'b0, 4'b0010, 1'b1, 2'd0, 1'b1, 4'b0001, 4'b0001};
        tbl[16] = '{1'b0, 4'b0000, 1'b0, 2'd0, 1'b0, 4'b0000, 4'b0000};
        tbl[17] = '{1'b0, 4'b0000, 1'b0, 2'd0, 1'b0, 4'b0000, 4'b0000};

        // Reset, then ten idle cycles.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 4'b0000, 1'b0);
            check("idle_outputs", {sel, out_valid, gnt, ack}, 11'd0);
        end

        // All four requesting with ready high: grant order 0,1,2,3,0.
        prev_v     = 1'b0;
        last_ack_c = -1;
        for (int c = 0; c < 80 && starts.size() < 5; c++) begin
            cycle(1'b0, 4'b1111, 1'b1);
            if (out_valid && !prev_v) starts.push_back(int'(sel));
            if (ack != 4'b0000) begin
                check("ack_onehot", {31'd0, $onehot(ack)}, 32'd1);
`ifndef ARB_BURST_EN
                if (last_ack_c >= 0) check("ack_spacing", c - last_ack_c, 2);
`endif
                last_ack_c = c;
            end
            prev_v = out_valid;
        end
        check("rr_order_count", starts.size(), 5);
        foreach (starts[i]) check("rr_order", starts[i], i % 4);

        // Directed table from a fresh reset.
        do_reset();
        foreach (tbl[i]) begin
            cycle(tbl[i].rst, tbl[i].req, tbl[i].rdy);
            check($sformatf("tbl_row%0d", i), {sel, out_valid, gnt, ack},
                  {tbl[i].sel, tbl[i].vld, tbl[i].gnt, tbl[i].ack});
        end

        // Channel 2 held off by out_ready=0; request dropped on the second cycle.
        flush();
        cycle(1'b0, 4'b0100, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, (i == 0) ? 4'b0100 : 4'b0000, 1'b0);
            check("hold_stable", {sel, out_valid, gnt, ack}, {2'd2, 1'b1, 4'b0100, 4'b0000});
        end
        ack_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 4'b0000, (i == 0));
            if (i == 0) check("hold_ack", ack, 4'b0100);
            if (ack != 4'b0000) ack_cnt++;
        end
        check("hold_ack_once", ack_cnt, 1);

        // Reset in the middle of a grant: no ack, outputs back to reset values.
        flush();
        cycle(1'b0, 4'b1000, 1'b0);
        cycle(1'b0, 4'b1000, 1'b0);
        check("pre_rst_grant", {sel, out_valid, gnt}, {2'd3, 1'b1, 4'b1000});
        cycle(1'b1, 4'b1111, 1'b0);
        check("rst_no_ack", ack, 4'b0000);
        cycle(1'b0, 4'b1111, 1'b0);
        check("post_rst_idle", {sel, out_valid, gnt, ack}, 11'd0);
        cycle(1'b0, 4'b1111, 1'b0);
        check("post_rst_first", {sel, out_valid, gnt}, {2'd0, 1'b1, 4'b0001});
        flush();

`ifdef ARB_BURST_EN
        // Burst of MAX_BURST beats for a channel that keeps requesting.
        do_reset();
        cycle(1'b0, 4'b0010, 1'b1);
        check("burst_start_idle", out_valid, 1'b0);
        for (int i = 0; i < MAX_BURST; i++) begin
            cycle(1'b0, 4'b0010, 1'b1);
            check("burst_beat", {sel, out_valid, ack}, {2'd1, 1'b1, 4'b0010});
        end
        cycle(1'b0, 4'b0010, 1'b1);
        check("burst_gap", {out_valid, ack}, 5'd0);
        cycle(1'b0, 4'b0010, 1'b1);
        check("burst_regrant", {sel, out_valid, gnt}, {2'd1, 1'b1, 4'b0010});
        flush();
`endif

        // Random traffic against the model, with occasional resets.
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(0, 63) == 0), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
